// File: rtl/spectrum_pkg.sv
// Shared spectrum-processing constants and the peak detector state encoding.
// Consumers: magn_peak_detect (optional DC-bin skip via PEAK_DC_SKIP_EN).
package spectrum_pkg;

  localparam int unsigned NPOINTS = 1024;
  localparam int unsigned BIN_W   = 10;
  localparam int unsigned MAGN_W  = 64;

  typedef enum logic {
    SCAN = 1'b0,
    HOLD = 1'b1
  } pk_state_e;

  // Closing condition mismatch: in_last and the final-bin position must coincide.
  function automatic logic frame_len_err(input logic last, input logic at_end);
    return last ^ at_end;
  endfunction

endpackage : spectrum_pkg

// File: rtl/magn_peak_detect.sv
// Per-frame peak search over magnitude-squared bins; reports max value, its bin and a length error.
// Optional build macro PEAK_DC_SKIP_EN excludes bin 0 from the search.
module magn_peak_detect #(
  parameter int unsigned NPOINTS = spectrum_pkg::NPOINTS,
  parameter int unsigned BIN_W   = spectrum_pkg::BIN_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [spectrum_pkg::MAGN_W-1:0] in_magn,
  input  logic                           in_last,
  output logic                           pk_valid,
  input  logic                           pk_ready,
  output logic [spectrum_pkg::MAGN_W-1:0] pk_magn,
  output logic [BIN_W-1:0]               pk_bin,
  output logic                           pk_err
);

  import spectrum_pkg::*;

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NPOINTS - 1);
`ifdef PEAK_DC_SKIP_EN
  localparam logic [BIN_W-1:0] FIRST_BIN = BIN_W'(1);
`else
  localparam logic [BIN_W-1:0] FIRST_BIN = BIN_W'(0);
`endif

  pk_state_e          r_state;
  pk_state_e          w_next;
  logic               r_in_ready;
  logic               r_pk_valid;
  logic [BIN_W-1:0]   r_cnt;
  logic [MAGN_W-1:0]  r_max;
  logic [BIN_W-1:0]   r_bin;
  logic               r_err;

  logic               w_accept;
  logic               w_at_end;
  logic               w_close;
  logic               w_release;
  logic               w_elig;
  logic               w_first;
  logic               w_greater;
  logic               w_upd;
  logic               w_clr;

  assign w_accept  = in_valid & r_in_ready;
  assign w_at_end  = (r_cnt == LAST_BIN);
  assign w_close   = w_accept & (in_last | w_at_end);
  assign w_release = r_pk_valid & pk_ready;
  assign w_first   = (r_cnt == FIRST_BIN);
  assign w_greater = (in_magn > r_max);

`ifdef PEAK_DC_SKIP_EN
  // Bin 0 still advances the counter but only wipes the previous frame's result.
  assign w_elig = (r_cnt != '0);
`else
  assign w_elig = 1'b1;
`endif

  assign w_upd = w_accept & w_elig & (w_first | w_greater);
  assign w_clr = w_accept & ~w_elig;

  // State register plus registered handshake flags decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= SCAN;
      r_in_ready <= 1'b1;
      r_pk_valid <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next == SCAN);
      r_pk_valid <= (w_next == HOLD);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      SCAN: if (w_close)   w_next = HOLD;
      HOLD: if (w_release) w_next = SCAN;
      default:             w_next = SCAN;
    endcase
  end

  // Bin counter: wraps only through frame close or result release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= w_close ? '0 : r_cnt + BIN_W'(1);
    end else if (w_release) begin
      r_cnt <= '0;
    end
  end

  // Running maximum; strict compare keeps the lowest bin on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max <= '0;
      r_bin <= '0;
    end else if (w_upd) begin
      r_max <= in_magn;
      r_bin <= r_cnt;
    end else if (w_clr) begin
      r_max <= '0;
      r_bin <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_close) begin
      r_err <= frame_len_err(in_last, w_at_end);
    end
  end

  assign in_ready = r_in_ready;
  assign pk_valid = r_pk_valid;
  assign pk_magn  = r_max;
  assign pk_bin   = r_bin;
  assign pk_err   = r_err;

endmodule : magn_peak_detect

// File: tb/tb_magn_peak_detect.sv
// Bench for magn_peak_detect: directed frame table, stall/reset sequences, random frames vs model.
module tb_magn_peak_detect;

  localparam int NP = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_magn;
  logic        in_last;
  logic        pk_valid;
  logic        pk_ready;
  logic [63:0] pk_magn;
  logic [9:0]  pk_bin;
  logic        pk_err;

  int errors = 0;
  int checks = 0;

  logic [63:0] rnd [NP];

  typedef struct {
    int          pat;
    int          last_at;
    int          nbeats;
    int          stall;
    logic [63:0] e_magn;
    int          e_bin;
    bit          e_err;
  } vec_t;

  vec_t vecs [6];

  magn_peak_detect dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_magn  (in_magn),
    .in_last  (in_last),
    .pk_valid (pk_valid),
    .pk_ready (pk_ready),
    .pk_magn  (pk_magn),
    .pk_bin   (pk_bin),
    .pk_err   (pk_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] magn_of(input int pat, input int b);
    case (pat)
      0:       return 64'(b) * 64'd3;
      1:       return (b == 5 || b == 700) ? 64'd1000 : 64'd10;
      2:       return (b == 0) ? 64'h8000_0000_0000_0000 : ((b == 9) ? 64'd50 : 64'd1);
      default: return rnd[b];
    endcase
  endfunction

  // Drives nbeats beats; returns right after the edge that accepts the last one (at the next negedge).
  task automatic send_frame(input int pat, input int last_at, input int nbeats, input bit gaps);
    for (int b = 0; b < nbeats; b++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_magn  = {$urandom, $urandom};
          in_last  = 1'($urandom_range(0, 1));
        end
      end
      @(negedge clk);
      if (in_ready !== 1'b1) chk($sformatf("in_ready_beat%0d", b), 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_magn  = magn_of(pat, b);
      in_last  = (b == last_at);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_magn  = {$urandom, $urandom};
  endtask

  // Checks a held result, keeps it held for `stall` cycles, then completes the handshake.
  task automatic check_result(input string tag, input logic [63:0] e_magn, input int e_bin,
                              input bit e_err, input int stall);
    chk({tag, "_pk_valid"}, 64'(pk_valid), 64'd1);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_pk_magn"}, pk_magn, e_magn);
    chk({tag, "_pk_bin"}, 64'(pk_bin), 64'(e_bin));
    chk({tag, "_pk_err"}, 64'(pk_err), 64'(e_err));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({tag, "_stall_state"}, {62'd0, pk_valid, in_ready}, 64'd2);
      chk({tag, "_stall_magn"}, pk_magn, e_magn);
      chk({tag, "_stall_bin_err"}, {53'd0, pk_err, pk_bin}, {53'd0, e_err, 10'(e_bin)});
    end
    pk_ready = 1'b1;
    @(negedge clk);
    pk_ready = 1'b0;
    chk({tag, "_release_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_release_pk_valid"}, 64'(pk_valid), 64'd0);
  endtask

  // Reference: maximum over the eligible bins, then the lowest bin holding it.
  task automatic model(input int nbeats, input int last_at, output logic [63:0] m,
                       output int bin, output bit err);
    int first;
`ifdef PEAK_DC_SKIP_EN
    first = 1;
`else
    first = 0;
`endif
    m = 64'd0;
    for (int b = first; b < nbeats; b++) if (rnd[b] > m) m = rnd[b];
    bin = first;
    for (int b = nbeats - 1; b >= first; b--) if (rnd[b] == m) bin = b;
    err = !(nbeats == NP && last_at == NP - 1);
  endtask

  initial begin
    logic [63:0] dc_magn;
    int          dc_bin;
    logic [63:0] em;
    int          eb;
    bit          ee;
    int          last_at;
    int          nbeats;
    int          mode;

`ifdef PEAK_DC_SKIP_EN
    dc_magn = 64'd50;
    dc_bin  = 9;
`else
    dc_magn = 64'h8000_0000_0000_0000;
    dc_bin  = 0;
`endif
    vecs[0] = '{0, 1023, 1024, 0,  64'd3069, 1023, 1'b0};
    vecs[1] = '{1, 1023, 1024, 20, 64'd1000, 5,    1'b0};
    vecs[2] = '{2, 1023, 1024, 0,  dc_magn,  dc_bin, 1'b0};
    vecs[3] = '{0, 511,  512,  0,  64'd1533, 511,  1'b1};
    vecs[4] = '{1, 511,  512,  3,  64'd1000, 5,    1'b1};
    vecs[5] = '{0, -1,   1024, 0,  64'd3069, 1023, 1'b1};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_magn  = '0;
    in_last  = 1'b0;
    pk_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {pk_magn[31:0], 20'd0, pk_bin, pk_err, pk_valid}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].pat, vecs[i].last_at, vecs[i].nbeats, 1'b0);
      check_result($sformatf("vec%0d", i), vecs[i].e_magn, vecs[i].e_bin, vecs[i].e_err,
                   vecs[i].stall);
    end

    // Reset in the middle of a frame, then a clean frame from bin 0.
    send_frame(0, -1, 300, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midreset_pk_valid", 64'(pk_valid), 64'd0);
    chk("midreset_pk_magn", pk_magn, 64'd0);
    chk("midreset_bin_err", {53'd0, pk_err, pk_bin}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(1, 1023, 1024, 1'b0);
    check_result("post_reset", 64'd1000, 5, 1'b0, 0);

    for (int f = 0; f < 5; f++) begin
      mode = $urandom_range(0, 2);
      for (int b = 0; b < NP; b++)
        rnd[b] = (mode == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0:       begin last_at = NP - 1; nbeats = NP; end
        1:       begin last_at = $urandom_range(1, NP - 2); nbeats = last_at + 1; end
        default: begin last_at = -1; nbeats = NP; end
      endcase
      send_frame(9, last_at, nbeats, 1'b1);
      model(nbeats, last_at, em, eb, ee);
      check_result($sformatf("rand%0d", f), em, eb, ee, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_magn_peak_detect

// File: doc/magn_peak_detect.md
MAGN_PEAK_DETECT -- requirements
Module: magn_peak_detect

Interface
REQ-001 SHALL have parameter NPOINTS, default 1024, number of bins per frame.
REQ-002 SHALL have parameter BIN_W, default 10, bin index width, equal to log2(NPOINTS).
REQ-003 SHALL have port clk, input, 1 bit, single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit, in_magn/in_last valid.
REQ-006 SHALL have port in_ready, output, 1 bit, block accepts an input beat.
REQ-007 SHALL have port in_magn, input, 64 bits, unsigned magnitude-squared (re²+im²) of the current bin.
REQ-008 SHALL have port in_last, input, 1 bit, marks the final bin of a frame.
REQ-009 SHALL have port pk_valid, output, 1 bit, peak result available.
REQ-010 SHALL have port pk_ready, input, 1 bit, downstream accepts the result.
REQ-011 SHALL have port pk_magn, output, 64 bits, largest magnitude in the frame.
REQ-012 SHALL have port pk_bin, output, BIN_W bits, bin index of pk_magn.
REQ-013 SHALL have port pk_err, output, 1 bit, frame length differed from NPOINTS.

Function
REQ-014 SHALL accept an input beat only when in_valid and in_ready are both 1.
REQ-015 SHALL count accepted beats with bin counter cnt (0..NPOINTS-1); each accepted beat has bin index cnt.
REQ-016 SHALL use FSM states SCAN and HOLD; SCAN: in_ready=1, pk_valid=0; HOLD: in_ready=0, pk_valid=1.
REQ-017 SHALL use the first eligible beat of a frame to load max/bin unconditionally.
REQ-018 SHALL replace max/bin on later beats only when in_magn > max (strict), so on a tie the lowest bin wins.
REQ-019 SHALL close a frame on an accepted beat with in_last=1, or with cnt=NPOINTS-1.
REQ-020 SHALL, on frame close, go SCAN->HOLD with pk_valid=1 in the next cycle (latency 1 cycle after the closing beat), including that beat in the comparison.
REQ-021 SHALL set pk_err=1 if in_last=1 with cnt≠NPOINTS-1, or if cnt=NPOINTS-1 with in_last=0.
REQ-022 SHALL hold pk_magn, pk_bin and pk_err stable throughout HOLD.
REQ-023 SHALL, on pk_valid&pk_ready, go HOLD->SCAN, clear cnt, and assert in_ready the next cycle; no beat is accepted in the handshake cycle.
REQ-024 SHALL handle cnt wrap-around only via frame close (cnt returns to 0); 64-bit compare is unsigned, no truncation.

Reset
REQ-025 SHALL, when rst_n=0, immediately set state=SCAN, cnt=0, pk_valid=0, pk_magn=0, pk_bin=0, pk_err=0, in_ready=1 after release.
REQ-026 SHALL discard any partial frame or pending result on reset mid-operation; the first beat after release is bin 0.

Configuration
REQ-027 SHALL compile the DC-skip feature only when macro PEAK_DC_SKIP_EN is defined.
REQ-028 SHALL, with PEAK_DC_SKIP_EN, exclude bin 0 from the search (bin 1 is the first eligible beat) while bin 0 still counts toward frame length.
REQ-029 SHALL, without PEAK_DC_SKIP_EN, treat bin 0 as eligible.

Structure
REQ-030 SHALL take NPOINTS, BIN_W, MAGN_W=64 and the SCAN/HOLD state encoding from shared package spectrum_pkg.
REQ-031 SHALL have no sub-module; comparator and counter stay inline.

Verification
REQ-032 SHALL check: 1024 beats with in_magn=bin*3 and in_last at bin 1023 -> pk_magn=3069, pk_bin=1023, pk_err=0, pk_valid one cycle after the last beat.
REQ-033 SHALL check: bins 5 and 700 both =1000, others 10 -> pk_bin=5, pk_magn=1000.
REQ-034 SHALL check: bin 0=2^63, bin 9=50, others 1 -> pk_bin=0 without PEAK_DC_SKIP_EN; pk_bin=9, pk_magn=50 with it.
REQ-035 SHALL check: in_last at bin 511 -> pk_err=1, pk_bin over bins 0..511; no in_last by 1023 -> close at 1023 with pk_err=1.
REQ-036 SHALL check: pk_ready=0 for 20 cycles -> outputs stable and in_ready=0; then pk_ready=1 -> in_ready=1 the next cycle.
REQ-037 SHALL check: rst_n low at bin 300 -> pk_valid=0 and outputs=0; the next full frame is reported correctly from bin 0.
